// File: rtl/filter_pkg.sv
// Definitions shared by the filter GPU datapath stages: FSM state encoding,
// ALU flag bit positions and the accumulator width rule.
package filter_pkg;

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam int FLAG_OVF   = 3;
   localparam int FLAG_CARRY = 2;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_NEG   = 0;

   // Wide enough to sum ROWS signed N-bit values without wrapping.
   function automatic int acc_w(input int n, input int rows);
      return n + $clog2(rows) + 1;
   endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational normalizer: arithmetic right shift of a signed accumulator,
// then clamp to an unsigned OUT_W pixel with a saturation indicator.
module sat_shift #(
   parameter int ACC_W = 21,
   parameter int SHIFT = 4,
   parameter int OUT_W = 8
) (
   input  logic signed [ACC_W-1:0] val_i,
   output logic        [OUT_W-1:0] pixel_o,
   output logic                    sat_o
);

   logic signed [ACC_W-1:0] shifted;

   assign shifted = val_i >>> SHIFT;

   // Assumes ACC_W >= OUT_W + 2, so a sign bit sits above the pixel bits.
   always_comb begin
      pixel_o = shifted[OUT_W-1:0];
      sat_o   = 1'b0;
      if (shifted[ACC_W-1]) begin
         pixel_o = '0;
         sat_o   = 1'b1;
      end else if (|shifted[ACC_W-2:OUT_W]) begin
         pixel_o = '1;
         sat_o   = 1'b1;
      end
   end

endmodule

// File: rtl/vec_row_accumulator.sv
// Accumulates ROWS signed row sums into one filtered pixel, normalizes and
// saturates it, and hands it to the frame writer with per-frame last marking.
module vec_row_accumulator
   import filter_pkg::*;
#(
   parameter int N      = 18,
   parameter int ROWS   = 3,
   parameter int SHIFT  = 4,
   parameter int OUT_W  = 8,
   parameter int PIXELS = 65536
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_sum,
   input  logic [3:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_pixel,
   output logic             out_sat,
   output logic             out_ovf,
   output logic             out_last
);

   localparam int ACC_W = acc_w(N, ROWS);
   localparam int RC_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

   // Handshake: a beat moves when in_valid && in_ready, a pixel retires when
   // out_valid && out_ready; both are evaluated on the same rising edge.
   state_e                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic        [RC_W-1:0]   row_cnt_q, row_cnt_d;
   logic        [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic                     ovf_q, ovf_d;
   logic        [OUT_W-1:0]  pixel_q, pixel_d;
   logic                     sat_q, sat_d;
   logic                     out_ovf_q, out_ovf_d;

   logic signed [ACC_W-1:0]  beat_ext;
   logic signed [ACC_W-1:0]  sum_full;
   logic        [OUT_W-1:0]  norm_pixel;
   logic                     norm_sat;
   logic                     accept, retire, last_beat, ovf_now;
   logic                     unused_flags;

   assign unused_flags = ^in_flags[FLAG_CARRY:FLAG_NEG];
   assign beat_ext     = {{(ACC_W-N){in_sum[N-1]}}, in_sum};
   assign sum_full     = acc_q + beat_ext;

   sat_shift #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_sat_shift (
      .val_i   (sum_full),
      .pixel_o (norm_pixel),
      .sat_o   (norm_sat)
   );

   // rst gates in_ready so nothing is accepted during the reset cycle.
   assign in_ready  = ~rst & ((state_q == ST_ACC) | out_ready);
   assign accept    = in_valid & in_ready;
   assign retire    = (state_q == ST_HOLD) & out_ready;
   assign last_beat = accept & (row_cnt_q == RC_W'(ROWS-1));
   assign ovf_now   = ovf_q | in_flags[FLAG_OVF];

   assign out_valid = (state_q == ST_HOLD);
   assign out_pixel = pixel_q;
   assign out_sat   = sat_q;
   assign out_ovf   = out_ovf_q;
   assign out_last  = out_valid & (pix_cnt_q == PIX_W'(PIXELS-1));

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      row_cnt_d = row_cnt_q;
      pix_cnt_d = pix_cnt_q;
      ovf_d     = ovf_q;
      pixel_d   = pixel_q;
      sat_d     = sat_q;
      out_ovf_d = out_ovf_q;

      if (retire) begin
         pix_cnt_d = (pix_cnt_q == PIX_W'(PIXELS-1)) ? '0 : pix_cnt_q + PIX_W'(1);
         state_d   = ST_ACC;
      end

      if (last_beat) begin
         acc_d     = '0;
         row_cnt_d = '0;
         ovf_d     = 1'b0;
         pixel_d   = norm_pixel;
         sat_d     = norm_sat;
         out_ovf_d = ovf_now;
         state_d   = ST_HOLD;
      end else if (accept) begin
         acc_d     = sum_full;
         row_cnt_d = row_cnt_q + RC_W'(1);
         ovf_d     = ovf_now;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_ACC;
         acc_q     <= '0;
         row_cnt_q <= '0;
         pix_cnt_q <= '0;
         ovf_q     <= 1'b0;
         pixel_q   <= '0;
         sat_q     <= 1'b0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         row_cnt_q <= row_cnt_d;
         pix_cnt_q <= pix_cnt_d;
         ovf_q     <= ovf_d;
         pixel_q   <= pixel_d;
         sat_q     <= sat_d;
         out_ovf_q <= out_ovf_d;
      end
   end

endmodule

// File: tb/tb_vec_row_accumulator.sv
// Directed bench for vec_row_accumulator with a frame of 4 pixels; a pixel
// model fed from accepted beats is compared against every retired pixel.
module tb_vec_row_accumulator;

   localparam int N      = 18;
   localparam int ROWS   = 3;
   localparam int SHIFT  = 4;
   localparam int OUT_W  = 8;
   localparam int PIXELS = 4;

   typedef struct packed {
      logic [OUT_W-1:0] pixel;
      logic             sat;
      logic             ovf;
      logic             last;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N-1:0]     in_sum = '0;
   logic [3:0]       in_flags = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [OUT_W-1:0] out_pixel;
   logic             out_sat;
   logic             out_ovf;
   logic             out_last;

   int   pass_cnt = 0;
   int   check_cnt = 0;
   int   cyc = 0;
   int   done_cyc = -10;
   int   stall_total = 0;
   int   last_seen = 0;

   exp_t exp_q[$];
   int   m_sum = 0;
   int   m_cnt = 0;
   int   m_pix = 0;
   logic m_ovf = 1'b0;

   vec_row_accumulator #(
      .N(N), .ROWS(ROWS), .SHIFT(SHIFT), .OUT_W(OUT_W), .PIXELS(PIXELS)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pixel(out_pixel), .out_sat(out_sat),
      .out_ovf(out_ovf), .out_last(out_last)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      check_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   // model: floor division for the normalizing shift, then unsigned clamp
   task automatic model_clear();
      m_sum = 0; m_cnt = 0; m_pix = 0; m_ovf = 1'b0;
      exp_q.delete();
      done_cyc = -10;
   endtask

   task automatic model_beat(input int s, input logic [3:0] f);
      int   q;
      exp_t e;
      m_sum += s;
      m_ovf |= f[3];
      m_cnt++;
      if (m_cnt == ROWS) begin
         q = m_sum / (1 << SHIFT);
         if (m_sum < 0 && (m_sum % (1 << SHIFT)) != 0) q = q - 1;
         if (q < 0) begin e.pixel = '0; e.sat = 1'b1; end
         else if (q > (1 << OUT_W) - 1) begin e.pixel = '1; e.sat = 1'b1; end
         else begin e.pixel = OUT_W'(q); e.sat = 1'b0; end
         e.ovf  = m_ovf;
         e.last = (m_pix == PIXELS - 1);
         exp_q.push_back(e);
         done_cyc = cyc;
         m_pix = (m_pix + 1) % PIXELS;
         m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
      end
   endtask

   // driver tasks
   task automatic send_beat(input int s, input logic [3:0] f);
      bit acc = 0;
      int waited = 0;
      in_valid = 1'b1;
      in_sum   = N'(s);
      in_flags = f;
      while (!acc && waited < 20) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            model_beat(s, f);
         end else begin
            waited++;
         end
         @(posedge clk); #1;
      end
      stall_total += waited;
      if (!acc) begin
         check_cnt++;
         $display("FAIL beat_accept: got no accept in %0d cycles required accept", waited);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      check("post_rst_in_ready", int'(in_ready), 1);
      check("post_rst_out_valid", int'(out_valid), 0);
      check("post_rst_out_pixel", int'(out_pixel), 0);
      check("post_rst_out_sat", int'(out_sat), 0);
      check("post_rst_out_ovf", int'(out_ovf), 0);
      check("post_rst_out_last", int'(out_last), 0);
      @(posedge clk); #1;
   endtask

   // scoreboard: compare every retired pixel against the model
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (cyc == done_cyc + 1) check("latency_valid", int'(out_valid), 1);
         if (!out_valid) check("last_idle", int'(out_last), 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_cnt++;
               $display("FAIL unexpected_pixel: got pixel %0d required none", out_pixel);
            end else begin
               e = exp_q.pop_front();
               check("pixel", int'(out_pixel), int'(e.pixel));
               check("sat", int'(out_sat), int'(e.sat));
               check("ovf", int'(out_ovf), int'(e.ovf));
               check("last", int'(out_last), int'(e.last));
               if (out_last) last_seen++;
            end
         end
      end
   end

   initial begin
      @(posedge clk); #1;
      do_reset();

      // pixel 0: 400 >>> 4 = 25; non-overflow flag bits are ignored
      send_beat(100, 4'b0000);
      send_beat(200, 4'b0111);
      send_beat(100, 4'b0000);
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_p0_pixel", int'(out_pixel), 25);
      check("lit_p0_sat", int'(out_sat), 0);
      check("lit_p0_ovf", int'(out_ovf), 0);
      @(posedge clk); #1;
      idle(1);

      // pixel 1: -40 -> -3 -> clamp to 0
      send_beat(-50, 4'b0000);
      send_beat(10, 4'b0000);
      send_beat(0, 4'b0000);
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_p1_pixel", int'(out_pixel), 0);
      check("lit_p1_sat", int'(out_sat), 1);
      @(posedge clk); #1;
      idle(1);

      // pixel 2: 393213 >>> 4 = 24575 -> 255, ALU overflow on middle beat
      send_beat(131071, 4'b0000);
      send_beat(131071, 4'b1000);
      send_beat(131071, 4'b0000);
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_p2_pixel", int'(out_pixel), 255);
      check("lit_p2_sat", int'(out_sat), 1);
      check("lit_p2_ovf", int'(out_ovf), 1);
      @(posedge clk); #1;
      idle(1);

      // pixel 3 (last of frame): 144 >>> 4 = 9, writer stalls for 5 cycles
      send_beat(48, 4'b0000);
      send_beat(48, 4'b0000);
      out_ready = 1'b0;
      send_beat(48, 4'b0000);
      in_valid = 1'b1;
      in_sum   = N'(32);
      in_flags = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_out_valid", int'(out_valid), 1);
         check("stall_out_pixel", int'(out_pixel), 9);
         check("stall_out_last", int'(out_last), 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send_beat(32, 4'b0000);
      send_beat(32, 4'b0000);
      send_beat(32, 4'b0000);
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_p4_pixel", int'(out_pixel), 6);
      check("lit_p4_last", int'(out_last), 0);
      @(posedge clk); #1;
      idle(2);

      // full frame of 16s: four pixels of 3, last only on the 4th, then wrap
      do_reset();
      last_seen = 0;
      stall_total = 0;
      for (int i = 0; i < 12; i++) send_beat(16, 4'b0000);
      idle(2);
      check("frame_last_count", last_seen, 1);
      for (int i = 0; i < 3; i++) send_beat(16, 4'b0000);
      idle(2);
      check("wrap_last_count", last_seen, 1);
      check("no_bubble", stall_total, 0);

      // reset mid-accumulation discards the partial pixel
      send_beat(1000, 4'b1000);
      send_beat(1000, 4'b0000);
      do_reset();
      send_beat(16, 4'b0000);
      send_beat(16, 4'b0000);
      send_beat(16, 4'b0000);
      in_valid = 1'b0;
      @(negedge clk);
      check("lit_post_rst_pixel", int'(out_pixel), 3);
      check("lit_post_rst_ovf", int'(out_ovf), 0);
      @(posedge clk); #1;
      idle(3);

      check("drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
